regfile: RTL
============

// Module: regfile
// PURPOSE
//   General-purpose register file that sits directly upstream of the ALU.
//   Two combinational read ports drive the ALU A/B operands; one synchronous
//   write port accepts the write-back value (ALU result or load data).
//   Register 0 is hardwired to zero, following MIPS convention, so that
//   Zero/compare paths in the ALU see a constant 0 source.
// PARAMETERS
//   W   32  data width in bits; must match the ALU W
//   AW  5   address width; the register count is 2**AW (32 by default)
// PORTS
//   clock      in   1   rising-edge clock
//   reset      in   1   asynchronous reset, active-high
//   RegWrite   in   1   write enable, sampled at the rising edge of clock
//   WriteReg   in   AW  destination register index
//   WriteData  in   W   value to write
//   ReadReg1   in   AW  source index for port 1 (feeds ALU A)
//   ReadReg2   in   AW  source index for port 2 (feeds ALU B)
//   ReadData1  out  W   contents of ReadReg1
//   ReadData2  out  W   contents of ReadReg2
// BEHAVIOUR
//   - Storage: 2**AW-1 registers of W bits each, indices 1..2**AW-1.
//     Index 0 has no storage.
//   - Reset: reset=1 immediately clears every register to 0, with no wait for
//     clock. While reset is high, ReadData1 = ReadData2 = 0 and writes are
//     ignored.
//   - Reset mid-operation: reset asserted on the same edge as a write wins.
//     The write is dropped.
//   - Release: the first write can take effect on the first rising edge after
//     reset falls.
//   - Write: on posedge clock with reset=0, RegWrite=1 and WriteReg != 0,
//     reg[WriteReg] <= WriteData. The new value is visible on the read ports
//     after that edge (1-cycle write latency).
//   - Write to index 0: silently discarded, with no state change.
//   - RegWrite=0: no state change, whatever the values on WriteReg and
//     WriteData.
//   - Read: purely combinational, with zero latency.
//     ReadDataN = (ReadRegN == 0) ? 0 : reg[ReadRegN].
//   - Read ports are independent. ReadReg1 == ReadReg2 is legal and both
//     ports return the same value.
//   - Same-cycle read/write of one index: governed by REGFILE_BYPASS_EN
//     (see CONFIGURATION).
//   - Index 2**AW-1 is an ordinary register; there is no wrap-around and no
//     out-of-range case, because the AW-bit index covers the full set.
//   - No X propagation: all registers have a defined value after reset.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - If RegWrite=1, WriteReg != 0 and WriteReg == ReadRegN, then
//       ReadDataN = WriteData combinationally in the same cycle
//       (write-then-read).
//     - Index 0 is never bypassed and still reads 0.
//     - The bypass is suppressed while reset=1.
//   REGFILE_BYPASS_EN undefined:
//     - ReadDataN returns the old stored value until the write edge
//       (read-then-write).
//   The storage update timing is identical in both builds.
// TESTING
//   1. Reset: preload r5=0xDEADBEEF, then pulse reset with no clock edge.
//      -> ReadData1 (ReadReg1=5) = 0 immediately.
//   2. Basic write/read: write r7=0x00000012 and r9=0xFFFFFFFE with RegWrite=1.
//      Then ReadReg1=7, ReadReg2=9 -> 0x00000012 / 0xFFFFFFFE after the edge.
//   3. Register 0: RegWrite=1, WriteReg=0, WriteData=0x12345678, then
//      ReadReg1=ReadReg2=0 -> both read 0.
//   4. Write disable: RegWrite=0, WriteReg=3, WriteData=0xAAAA5555.
//      -> r3 keeps its prior value (0 after reset).
//   5. Same-cycle hazard: r4=1, then write r4=2 with ReadReg1=4 before the
//      edge -> ReadData1=2 with BYPASS_EN, 1 without; both read 2 after the edge.
//   6. Reset vs write: assert reset together with RegWrite=1, WriteReg=31,
//      WriteData=0xFFFFFFFF at the edge -> r31 = 0 after reset is released.

Source files
------------

// File: rtl/regfile_if.sv
// Register-file access bus: one write port and two combinational read ports.
// The master drives indices and write data; the register file returns read data.
interface regfile_if #(
   parameter int W  = 32,
   parameter int AW = 5
);
   logic          RegWrite;
   logic [AW-1:0] WriteReg;
   logic [W-1:0]  WriteData;
   logic [AW-1:0] ReadReg1;
   logic [AW-1:0] ReadReg2;
   logic [W-1:0]  ReadData1;
   logic [W-1:0]  ReadData2;

   modport master (
      output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
      input  ReadData1, ReadData2
   );

   modport slave (
      input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
      output ReadData1, ReadData2
   );
endinterface

// File: rtl/regfile.sv
// Register file feeding the ALU: 2**AW-1 registers with r0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile #(
   parameter int W  = 32,
   parameter int AW = 5
) (
   input logic       clock,
   input logic       reset,
   regfile_if.slave  bus
);
   localparam int NREG = 1 << AW;

   // Index 0 has no storage, so the array starts at 1.
   logic [W-1:0] regs [1:NREG-1];
   logic [W-1:0] stored1;
   logic [W-1:0] stored2;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.RegWrite && (bus.WriteReg != '0)) begin
         regs[bus.WriteReg] <= bus.WriteData;
      end
   end

   always_comb begin
      stored1 = '0;
      stored2 = '0;
      if (bus.ReadReg1 != '0) begin
         stored1 = regs[bus.ReadReg1];
      end
      if (bus.ReadReg2 != '0) begin
         stored2 = regs[bus.ReadReg2];
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic bypass_ok;

   // Forward only a real write: never to r0 and never while reset clears storage.
   always_comb begin
      bypass_ok     = !reset && bus.RegWrite && (bus.WriteReg != '0);
      bus.ReadData1 = stored1;
      bus.ReadData2 = stored2;
      if (bypass_ok && (bus.WriteReg == bus.ReadReg1)) begin
         bus.ReadData1 = bus.WriteData;
      end
      if (bypass_ok && (bus.WriteReg == bus.ReadReg2)) begin
         bus.ReadData2 = bus.WriteData;
      end
   end
`else
   always_comb begin
      bus.ReadData1 = stored1;
      bus.ReadData2 = stored2;
   end
`endif
endmodule
